multdiv_unit: RTL
=================

MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 data_operandA  input  32  signed multiplicand or dividend, sampled only in a start cycle.
REQ-005 data_operandB  input  32  signed multiplier or divisor, sampled only in a start cycle.
REQ-006 ctrl_MULT  input  1  one-cycle start pulse for a signed multiply.
REQ-007 ctrl_DIV  input  1  one-cycle start pulse for a signed divide.
REQ-008 data_result  output  32  low 32 bits of the product, or the quotient.
REQ-009 data_exception  output  1  overflow or divide-by-zero flag, valid while data_resultRDY=1.
REQ-010 data_resultRDY  output  1  one-cycle completion pulse.

Function
REQ-011 The FSM SHALL have four states (IDLE, MUL, DIV, DONE) and leave IDLE only on a start pulse.
REQ-012 Start cycle = cycle 0: operands are latched, the iteration counter is cleared, and the FSM enters MUL or DIV.
REQ-013 Multiply SHALL use radix-4 modified Booth recoding on a 65-bit {acc, multiplier, guard} register.
- one Booth step per cycle in MUL, cycles 1..16 (16 steps)
- arithmetic right shift by 2 after each step
REQ-014 Multiply SHALL enter DONE in cycle 17.
REQ-015 Divide SHALL perform restoring division on operand magnitudes, one quotient bit per cycle in DIV, cycles 1..32, and enter DONE in cycle 33.
REQ-016 In DONE the quotient sign SHALL be negated when operand signs differ.
- rounding: truncation toward zero
- remainder: discarded
REQ-017 In DONE, data_resultRDY SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-018 data_result and data_exception SHALL be registered in DONE and hold their values until the next DONE or reset.
REQ-019 Multiply exception SHALL be 1 when product bits [63:31] are not all equal (the product does not fit in signed 32 bits).
REQ-020 Divide by zero SHALL run the full 33-cycle latency and return data_result=0, data_exception=1.
REQ-021 0x80000000 / 0xFFFFFFFF SHALL return data_result=0x80000000, data_exception=1.
REQ-022 If ctrl_MULT and ctrl_DIV are both 1 in the same cycle, multiply SHALL take priority and the divide is ignored.
REQ-023 A start pulse in MUL, DIV or DONE SHALL abort the current operation and restart from cycle 0 with the new operands.
- the aborted operation produces no data_resultRDY pulse
REQ-024 Operand changes outside start cycles SHALL have no effect on the result.

Reset
REQ-025 While reset_n=0 at a clock edge, the block SHALL reset as follows:
- FSM to IDLE
- data_result=0, data_exception=0, data_resultRDY=0
- counter and internal datapath registers cleared
REQ-026 Reset asserted mid-operation SHALL discard that operation with no data_resultRDY pulse.
REQ-027 A start pulse coincident with reset_n=0 SHALL be ignored.

Structure
REQ-028 A shared package multdiv_pkg SHALL hold:
- state enum
- MUL_ITERS=16 and DIV_ITERS=32
- Booth recode enum (ZERO, PLUS1, PLUS2, MINUS1, MINUS2)
REQ-029 The 3-bit-to-partial-product Booth recoder SHALL be a combinational sub-module named booth_recode.
REQ-030 Shifts by constants SHALL be wiring, not barrel shifters.

Verification
REQ-031 Multiply 7 x -3 started at cycle 0 -> RDY pulse at cycle 17 only, result 0xFFFFFFEB, exception 0.
REQ-032 Multiply 0x00010000 x 0x00010000 -> result 0x00000000, exception 1; 0x80000000 x 1 -> result 0x80000000, exception 0.
REQ-033 Divide -7 / 2 -> RDY at cycle 33, result 0xFFFFFFFD, exception 0; 5 / 0 -> result 0, exception 1 at cycle 33.
REQ-034 Divide 0x80000000 / -1 -> result 0x80000000, exception 1; simultaneous ctrl_MULT and ctrl_DIV with operands 6 and 3 -> result 18 at cycle 17.
REQ-035 Divide started, new ctrl_MULT 5x5 at cycle 10 -> no RDY at original cycle 33, single RDY at cycle 27 with result 25.
REQ-036 reset_n=0 at cycle 8 of a multiply -> no RDY pulse, outputs 0; next start completes normally.

Source files
------------

// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared types and constants for the signed 32-bit
//               multiply/divide unit: FSM state encoding, iteration counts
//               and the radix-4 Booth recode operations.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

    localparam int MUL_ITERS = 16;   // radix-4 Booth: two multiplier bits per step
    localparam int DIV_ITERS = 32;   // restoring division: one quotient bit per step

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        PLUS1  = 3'd1,
        PLUS2  = 3'd2,
        MINUS1 = 3'd3,
        MINUS2 = 3'd4
    } booth_op_t;

    // Classic modified-Booth table on {b[i+1], b[i], b[i-1]}.
    function automatic booth_op_t booth_decode(input logic [2:0] bits);
        booth_op_t op;
        op = ZERO;
        case (bits)
            3'b000, 3'b111: op = ZERO;
            3'b001, 3'b010: op = PLUS1;
            3'b011:         op = PLUS2;
            3'b100:         op = MINUS2;
            3'b101, 3'b110: op = MINUS1;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multdiv_if.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_if
// Description : Operand/command/result bundle of the multiply/divide unit.
// Signals     : data_operandA  [31:0] signed multiplicand / dividend
//               data_operandB  [31:0] signed multiplier / divisor
//               ctrl_MULT              one-cycle multiply start pulse
//               ctrl_DIV               one-cycle divide start pulse
//               data_result    [31:0] low product word or quotient
//               data_exception         overflow / divide-by-zero flag
//               data_resultRDY         one-cycle completion pulse
// Modports    : master (requester), slave (the unit)
// Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_if;

    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );

endinterface
`default_nettype wire

// File: rtl/multdiv_unit_booth_recode.sv
`default_nettype none
// ============================================================================
// Module      : booth_recode
// Description : Combinational radix-4 Booth recoder. Maps a 3-bit multiplier
//               window onto a signed partial product of 0, +/-M or +/-2M.
// Ports       : i_bits  [2:0]  multiplier window {b[i+1], b[i], b[i-1]}
//               i_mcand [31:0] signed multiplicand M
//               o_pp    [33:0] signed partial product (34 bits holds +/-2M)
// Revision    : 1.0 - initial release
// ============================================================================
module booth_recode
    import multdiv_pkg::*;
(
    input  wire logic [2:0]  i_bits,
    input  wire logic [31:0] i_mcand,
    output logic      [33:0] o_pp
);

    logic [33:0] w_m1;
    logic [33:0] w_m2;
    booth_op_t   w_op;

    // Sign-extended M and 2M; the doubling is plain wiring.
    assign w_m1 = {{2{i_mcand[31]}}, i_mcand};
    assign w_m2 = {i_mcand[31], i_mcand, 1'b0};

    always_comb begin
        w_op = booth_decode(i_bits);
        o_pp = '0;
        case (w_op)
            ZERO:    o_pp = '0;
            PLUS1:   o_pp = w_m1;
            PLUS2:   o_pp = w_m2;
            MINUS1:  o_pp = -w_m1;
            MINUS2:  o_pp = -w_m2;
            default: o_pp = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_unit
// Description : Signed 32-bit iterative multiply/divide unit.
//               Multiply: radix-4 Booth, 16 steps, result ready in cycle 17.
//               Divide  : restoring division on magnitudes, 32 steps, result
//               ready in cycle 33; quotient truncates toward zero.
// Ports       : clock    single clock, rising edge
//               reset_n  synchronous active-low reset
//               bus      multdiv_if.slave (operands, start pulses, results)
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_unit
    import multdiv_pkg::*;
(
    input  wire logic  clock,
    input  wire logic  reset_n,
    multdiv_if.slave   bus
);

    localparam logic [4:0]  c_mul_last = 5'(MUL_ITERS - 1);
    localparam logic [4:0]  c_div_last = 5'(DIV_ITERS - 1);
    localparam logic [31:0] c_int_min  = 32'h8000_0000;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_count;
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [64:0] r_mreg;     // {acc[31:0], multiplier[31:0], guard}
    logic [31:0] r_rem;
    logic [31:0] r_quo;      // dividend magnitude shifting out, quotient shifting in
    logic [31:0] r_dsr;      // divisor magnitude
    logic [31:0] r_result;
    logic        r_exc;

    logic        w_start_mul;
    logic        w_start_div;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [33:0] w_pp;
    logic [33:0] w_sum;
    logic [64:0] w_mul_next;
    logic [32:0] w_mul_hi;
    logic        w_mul_ovf;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic        w_div_ok;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_quo_signed;
    logic        w_div_by_zero;
    logic        w_div_ovf;

    // Multiply wins when both start pulses arrive together.
    assign w_start_mul = bus.ctrl_MULT;
    assign w_start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;

    assign w_abs_a = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
    assign w_abs_b = bus.data_operandB[31] ? -bus.data_operandB : bus.data_operandB;

    // ---------------------------------------------------------------- multiply
    booth_recode u_booth (
        .i_bits  (r_mreg[2:0]),
        .i_mcand (r_opa),
        .o_pp    (w_pp)
    );

    // acc is widened to 34 bits so adding +/-2M cannot wrap. The 2-bit
    // arithmetic shift keeps bits [66:2] of {sum, multiplier, guard}; the two
    // extension bits make the replicated sign unnecessary.
    assign w_sum      = {{2{r_mreg[64]}}, r_mreg[64:33]} + w_pp;
    assign w_mul_next = {w_sum, r_mreg[32:2]};

    // Product is w_mul_next[64:1]; product bits [63:31] must all agree.
    assign w_mul_hi  = w_mul_next[64:32];
    assign w_mul_ovf = ~((&w_mul_hi) | ~(|w_mul_hi));

    // ------------------------------------------------------------------ divide
    // Partial remainder stays below the divisor (<= 2^31), so the shifted
    // value fits 32 bits and bit 32 of the difference is a clean borrow.
    assign w_div_shift  = {r_rem, r_quo[31]};
    assign w_div_diff   = w_div_shift - {1'b0, r_dsr};
    assign w_div_ok     = ~w_div_diff[32];
    assign w_rem_next   = w_div_ok ? w_div_diff[31:0] : w_div_shift[31:0];
    assign w_quo_next   = {r_quo[30:0], w_div_ok};
    assign w_quo_signed = (r_opa[31] ^ r_opb[31]) ? -w_quo_next : w_quo_next;
    assign w_div_by_zero = (r_opb == 32'd0);
    assign w_div_ovf     = (r_opa == c_int_min) && (r_opb == 32'hFFFF_FFFF);

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = IDLE;
            MUL:     if (r_count == c_mul_last) w_state_next = DONE;
            DIV:     if (r_count == c_div_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        // A start pulse in any state aborts and restarts.
        if (w_start_mul) begin
            w_state_next = MUL;
        end else if (w_start_div) begin
            w_state_next = DIV;
        end
    end

    // ---------------------------------------------------------------- datapath
    // Results are loaded on the edge that enters DONE so they are already
    // valid while data_resultRDY is high, and hold until the next completion.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_mreg   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dsr    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_start_mul) begin
            r_count <= '0;
            r_opa   <= bus.data_operandA;
            r_opb   <= bus.data_operandB;
            r_mreg  <= {32'd0, bus.data_operandB, 1'b0};
        end else if (w_start_div) begin
            r_count <= '0;
            r_opa   <= bus.data_operandA;
            r_opb   <= bus.data_operandB;
            r_rem   <= '0;
            r_quo   <= w_abs_a;
            r_dsr   <= w_abs_b;
        end else begin
            case (r_state)
                MUL: begin
                    r_mreg  <= w_mul_next;
                    r_count <= r_count + 5'd1;
                    if (r_count == c_mul_last) begin
                        r_result <= w_mul_next[32:1];
                        r_exc    <= w_mul_ovf;
                    end
                end
                DIV: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 5'd1;
                    if (r_count == c_div_last) begin
                        if (w_div_by_zero) begin
                            r_result <= '0;
                            r_exc    <= 1'b1;
                        end else begin
                            r_result <= w_quo_signed;
                            r_exc    <= w_div_ovf;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = (r_state == DONE);

endmodule
`default_nettype wire
